// File: rtl/rram_imc_ctrl.sv
// Wishbone-programmed operation sequencer for the RRAM in-memory-compute macro:
// times WL/BL/SL pulses, strobes sense amps and ADCs, and captures results.
module rram_imc_ctrl #(
    parameter int unsigned ROWS     = 16,
    parameter int unsigned COLS     = 16,
    parameter int unsigned ADC_BITS = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wbs_cyc_i,
    input  logic                     wbs_stb_i,
    input  logic                     wbs_we_i,
    input  logic [3:0]               wbs_sel_i,
    input  logic [31:0]              wbs_adr_i,
    input  logic [31:0]              wbs_dat_i,
    output logic                     wbs_ack_o,
    output logic [31:0]              wbs_dat_o,
    input  logic                     enable_im,
    output logic [ROWS-1:0]          wl_en,
    output logic [COLS-1:0]          bl_en,
    output logic                     sl_en,
    output logic [1:0]               vsel,
    output logic                     csa_en,
    output logic                     adc_start,
    input  logic                     adc_done,
    input  logic [COLS*ADC_BITS-1:0] adc_data,
    output logic                     irq
);

    localparam int unsigned RES_W     = COLS * ADC_BITS;
    localparam int unsigned RES_WORDS = (RES_W + 31) / 32;
    localparam int unsigned RES_PAD   = RES_WORDS * 32;

    localparam logic [2:0] OP_FORM    = 3'd1;
    localparam logic [2:0] OP_SET     = 3'd2;
    localparam logic [2:0] OP_RESET   = 3'd3;
    localparam logic [2:0] OP_READ    = 3'd4;
    localparam logic [2:0] OP_COMPUTE = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PULSE, S_DISCH, S_SENSE, S_WAIT_ADC, S_CAPTURE, S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic               ie_q, ie_d;
    logic [ROWS-1:0]    row_q, row_d;
    logic [COLS-1:0]    col_q, col_d;
    logic [CNT_W-1:0]   pulse_q, pulse_d, settle_q, settle_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d, abort_q, abort_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               ack_q, ack_d, go_q, go_d;
    logic [31:0]        dat_q, dat_d;
    logic [ROWS-1:0]    wl_q, wl_d;
    logic [COLS-1:0]    bl_q, bl_d;
    logic               sl_q, sl_d, csa_q, csa_d, adcs_q, adcs_d, irq_q, irq_d;
    logic [1:0]         vsel_q, vsel_d;

    logic               hw_err, hw_abort, capture;
    logic               req, wr, locked, start_req, start_ok, drive, active;
    logic [4:0]         idx;
    logic [2:0]         clr;
    logic [31:0]        rdata;
    logic [RES_PAD-1:0] res_pad;
    logic               unused_adr;

    assign unused_adr = ^{wbs_adr_i[31:7], wbs_adr_i[1:0]};
    assign res_pad    = RES_PAD'(result_q);

    function automatic logic [CNT_W-1:0] load(input logic [CNT_W-1:0] n);
        return (n == '0) ? '0 : n - CNT_W'(1);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
        end
        return r;
    endfunction

    // Next-state logic of the operation engine
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hw_err   = 1'b0;
        hw_abort = 1'b0;
        capture  = 1'b0;
        active   = (state_q != S_IDLE) && (state_q != S_DONE);
        case (state_q)
            S_IDLE: if (go_q) begin
                state_d = S_SETUP;
                cnt_d   = load(settle_q);
            end
            S_SETUP: if (cnt_q == '0) begin
                state_d = S_PULSE;
                cnt_d   = load(pulse_q);
            end else cnt_d = cnt_q - CNT_W'(1);
            S_PULSE: if (cnt_q == '0) begin
                if (op_q == OP_READ || op_q == OP_COMPUTE) begin
                    state_d = S_SENSE;
                end else begin
                    state_d = S_DISCH;
                    cnt_d   = load(settle_q);
                end
            end else cnt_d = cnt_q - CNT_W'(1);
            S_SENSE: begin
                state_d = S_WAIT_ADC;
                cnt_d   = {{(CNT_W-1){1'b1}}, 1'b0};
            end
            S_WAIT_ADC: if (adc_done) begin
                state_d = S_CAPTURE;
                capture = 1'b1;
            end else if (cnt_q == '0) begin
                state_d = S_DISCH;
                cnt_d   = load(settle_q);
                hw_err  = 1'b1;
            end else cnt_d = cnt_q - CNT_W'(1);
            S_CAPTURE: begin
                state_d = S_DISCH;
                cnt_d   = load(settle_q);
            end
            S_DISCH: if (cnt_q == '0) state_d = S_DONE;
                     else cnt_d = cnt_q - CNT_W'(1);
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Losing the global enable mid-operation kills the run without completion
        if (active && !enable_im) begin
            state_d  = S_IDLE;
            hw_abort = 1'b1;
            hw_err   = 1'b1;
            capture  = 1'b0;
        end
    end

    // Bus decode, register file next values and registered array drive
    always_comb begin
        idx       = wbs_adr_i[6:2];
        req       = wbs_cyc_i && wbs_stb_i && !ack_q;
        wr        = req && wbs_we_i;
        locked    = busy_q || go_q;
        start_req = wr && (idx == 5'd0) && wbs_sel_i[0] && wbs_dat_i[3] && !locked;
        start_ok  = enable_im && (wbs_dat_i[2:0] >= OP_FORM) && (wbs_dat_i[2:0] <= OP_COMPUTE)
                    && (row_q != '0) && (col_q != '0)
                    && ((wbs_dat_i[2:0] != OP_READ) || ((row_q & (row_q - ROWS'(1))) == '0));
        clr       = (wr && (idx == 5'd4) && wbs_sel_i[0]) ? wbs_dat_i[3:1] : 3'b000;

        op_d     = op_q;
        ie_d     = ie_q;
        row_d    = row_q;
        col_d    = col_q;
        pulse_d  = pulse_q;
        settle_d = settle_q;
        if (wr && !locked) begin
            if (idx == 5'd0 && wbs_sel_i[0]) begin
                op_d = wbs_dat_i[2:0];
                ie_d = wbs_dat_i[4];
            end
            if (idx == 5'd1) row_d = ROWS'(merge(32'(row_q), wbs_dat_i, wbs_sel_i));
            if (idx == 5'd2) col_d = COLS'(merge(32'(col_q), wbs_dat_i, wbs_sel_i));
            if (idx == 5'd3 && wbs_sel_i[0]) begin
                pulse_d  = wbs_dat_i[CNT_W-1:0];
                settle_d = wbs_dat_i[CNT_W+7:8];
            end
        end
        go_d     = start_req && start_ok;
        done_d   = (done_q & ~clr[0]) | (state_d == S_DONE);
        err_d    = (err_q & ~clr[1]) | hw_err | (start_req && !start_ok);
        abort_d  = (abort_q & ~clr[2]) | hw_abort;
        result_d = capture ? adc_data : result_q;
        irq_d    = done_d && ie_d;

        rdata = '0;
        case (idx)
            5'd0: rdata = {27'd0, ie_q, 1'b0, op_q};
            5'd1: rdata = 32'(row_q);
            5'd2: rdata = 32'(col_q);
            5'd3: rdata = 32'(pulse_q) | (32'(settle_q) << 8);
            5'd4: rdata = {28'd0, abort_q, err_q, done_q, busy_q};
            default: begin
                for (int k = 0; k < RES_WORDS; k++) begin
                    if (idx == 5'(5 + k)) rdata = res_pad[32*k +: 32];
                end
            end
        endcase
        ack_d = req;
        dat_d = (req && !wbs_we_i) ? rdata : '0;

        drive  = (state_d == S_PULSE) || (state_d == S_SENSE) ||
                 (state_d == S_WAIT_ADC) || (state_d == S_CAPTURE);
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        wl_d   = drive ? row_q : '0;
        bl_d   = drive ? col_q : '0;
        sl_d   = drive;
        csa_d  = (state_d == S_SENSE) || (state_d == S_WAIT_ADC);
        adcs_d = (state_d == S_SENSE);
        vsel_d = 2'd0;
        if (busy_d) begin
            case (op_q)
                OP_FORM:  vsel_d = 2'd3;
                OP_SET:   vsel_d = 2'd1;
                OP_RESET: vsel_d = 2'd2;
                default:  vsel_d = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            ie_q     <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            pulse_q  <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            abort_q  <= 1'b0;
            result_q <= '0;
            ack_q    <= 1'b0;
            go_q     <= 1'b0;
            dat_q    <= '0;
            wl_q     <= '0;
            bl_q     <= '0;
            sl_q     <= 1'b0;
            csa_q    <= 1'b0;
            adcs_q   <= 1'b0;
            irq_q    <= 1'b0;
            vsel_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            ie_q     <= ie_d;
            row_q    <= row_d;
            col_q    <= col_d;
            pulse_q  <= pulse_d;
            settle_q <= settle_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            abort_q  <= abort_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            go_q     <= go_d;
            dat_q    <= dat_d;
            wl_q     <= wl_d;
            bl_q     <= bl_d;
            sl_q     <= sl_d;
            csa_q    <= csa_d;
            adcs_q   <= adcs_d;
            irq_q    <= irq_d;
            vsel_q   <= vsel_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign wl_en     = wl_q;
    assign bl_en     = bl_q;
    assign sl_en     = sl_q;
    assign vsel      = vsel_q;
    assign csa_en    = csa_q;
    assign adc_start = adcs_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_rram_imc_ctrl.sv
// Directed bench for rram_imc_ctrl: register access, SET/READ timing,
// ADC timeout, illegal starts, enable abort and asynchronous reset.
module tb_rram_imc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        enable_im;
    logic [15:0] wl_en, bl_en;
    logic        sl_en, csa_en, adc_start, adc_done, irq;
    logic [1:0]  vsel;
    logic [47:0] adc_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rram_imc_ctrl #(.ROWS(16), .COLS(16), .ADC_BITS(3), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .enable_im(enable_im),
        .wl_en(wl_en), .bl_en(bl_en), .sl_en(sl_en), .vsel(vsel),
        .csa_en(csa_en), .adc_start(adc_start), .adc_done(adc_done),
        .adc_data(adc_data), .irq(irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus transfer; returns in the acknowledge cycle
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rd);
        int n;
        n = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
        do begin
            step();
            n++;
        end while (!wbs_ack_o && n < 8);
        rd = wbs_dat_o;
        total++;
        if (wbs_ack_o !== 1'b1) begin
            bad++;
            $display("FAIL wb_ack adr=%h: got %b want 1", adr, wbs_ack_o);
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] rd;
        wb_xfer(1'b1, adr, dat, 4'hF, rd);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rd);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rd);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b0; enable_im = 1'b1; adc_done = 1'b0; adc_data = '0;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
        #23;
        total++;
        if ({wl_en, bl_en, sl_en, vsel, csa_en, adc_start, irq, wbs_ack_o} !== '0 || wbs_dat_o !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got wl=%h bl=%h sl=%b vsel=%0d want all 0", wl_en, bl_en, sl_en, vsel);
        end
        rst = 1'b1;
        step();
        wb_read(32'h10, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", rd); end
        wb_read(32'h0C, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_pulse: got %h want 0", rd); end
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        logic [31:0] rd2;
        wb_xfer(1'b1, 32'h08, 32'h0000_1234, 4'b0011, rd);
        wb_xfer(1'b1, 32'h08, 32'h0000_FFFF, 4'b0001, rd);
        wb_read(32'h08, rd);
        total++;
        if (rd !== 32'h0000_12FF) begin bad++; $display("FAIL col_lanes: got %h want 000012ff", rd); end
        step();
        total++;
        if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
            bad++; $display("FAIL ack_single: got ack=%b dat=%h want 0 0", wbs_ack_o, wbs_dat_o);
        end
        wb_write(32'h00, 32'h0000_0010);
        wb_read(32'h00, rd);
        total++;
        if (rd !== 32'h0000_0010) begin bad++; $display("FAIL ctrl_rd: got %h want 00000010", rd); end
        wb_write(32'h40, 32'hFFFF_FFFF);
        wb_read(32'h40, rd);
        wb_read(32'h18, rd2);
        total++;
        if (rd !== 32'h0 || rd2 !== 32'h0) begin
            bad++; $display("FAIL unmapped: got %h/%h want 0/0", rd, rd2);
        end
    endtask

    task automatic test_set();
        logic [31:0] rd;
        logic [15:0] exp_wl, exp_bl;
        logic [1:0]  exp_vsel;
        logic        exp_irq;
        wb_write(32'h04, 32'h0000_0004);
        wb_write(32'h08, 32'h0000_00F0);
        wb_write(32'h0C, 32'h0000_0205);
        wb_write(32'h00, 32'h0000_001A);
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_wl   = (k >= 3 && k <= 7) ? 16'h0004 : 16'h0;
            exp_bl   = (k >= 3 && k <= 7) ? 16'h00F0 : 16'h0;
            exp_vsel = (k >= 1 && k <= 9) ? 2'd1 : 2'd0;
            exp_irq  = (k >= 10);
            total++;
            if (wl_en !== exp_wl || bl_en !== exp_bl || sl_en !== (k >= 3 && k <= 7) ||
                vsel !== exp_vsel || irq !== exp_irq) begin
                bad++;
                $display("FAIL set_cycle%0d: got wl=%h bl=%h sl=%b vsel=%0d irq=%b want wl=%h bl=%h vsel=%0d irq=%b",
                         k, wl_en, bl_en, sl_en, vsel, irq, exp_wl, exp_bl, exp_vsel, exp_irq);
            end
        end
        wb_read(32'h10, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL set_status: got %h want 2", rd); end
        wb_read(32'h00, rd);
        total++;
        if (rd !== 32'h12) begin bad++; $display("FAIL set_ctrl_rd: got %h want 12", rd); end
        wb_write(32'h10, 32'h2);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL set_irq_clr: got %b want 0", irq); end
    endtask

    task automatic test_read();
        logic [31:0] rd;
        int n;
        wb_write(32'h04, 32'h0000_0001);
        wb_write(32'h08, 32'h0000_0FFF);
        wb_write(32'h0C, 32'h0000_0102);
        wb_write(32'h00, 32'h0000_001C);
        n = 0;
        while (adc_start !== 1'b1 && n < 40) begin step(); n++; end
        total++;
        if (adc_start !== 1'b1) begin bad++; $display("FAIL read_adc_start: got 0 want 1"); end
        step();
        total++;
        if (adc_start !== 1'b0 || csa_en !== 1'b1 || wl_en !== 16'h0001 || bl_en !== 16'h0FFF || vsel !== 2'd0) begin
            bad++;
            $display("FAIL read_wait: got start=%b csa=%b wl=%h bl=%h vsel=%0d want 0 1 0001 0fff 0",
                     adc_start, csa_en, wl_en, bl_en, vsel);
        end
        step(); step();
        adc_done = 1'b1; adc_data = 48'h2A5;
        step();
        adc_done = 1'b0; adc_data = 48'h0;
        n = 0;
        while (irq !== 1'b1 && n < 40) begin step(); n++; end
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL read_irq: got %b want 1", irq); end
        wb_read(32'h14, rd);
        total++;
        if (rd !== 32'h2A5) begin bad++; $display("FAIL read_result0: got %h want 2a5", rd); end
        wb_read(32'h10, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL read_status: got %h want 2", rd); end
        wb_write(32'h10, 32'h2);
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        int n;
        int i;
        wb_write(32'h04, 32'h0000_0003);
        wb_write(32'h08, 32'h0000_FFFF);
        wb_write(32'h0C, 32'h0000_0101);
        adc_data = 48'h111;
        wb_write(32'h00, 32'h0000_000D);
        n = 0;
        while (adc_start !== 1'b1 && n < 40) begin step(); n++; end
        i = 0;
        while (wl_en !== 16'h0 && i < 400) begin step(); i++; end
        total++;
        if (i != 256) begin bad++; $display("FAIL timeout_drop: got cycle %0d want 256", i); end
        repeat (4) step();
        wb_read(32'h10, rd);
        total++;
        if (rd !== 32'h6) begin bad++; $display("FAIL timeout_status: got %h want 6", rd); end
        wb_read(32'h14, rd);
        total++;
        if (rd !== 32'h2A5) begin bad++; $display("FAIL timeout_result: got %h want 2a5", rd); end
        wb_write(32'h10, 32'hE);
        wb_read(32'h10, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL timeout_w1c: got %h want 0", rd); end
        adc_data = 48'h0;
    endtask

    task automatic test_illegal();
        logic [31:0] rd;
        logic [31:0] ctl [3];
        logic [31:0] row [3];
        logic        en  [3];
        ctl[0] = 32'h0E; row[0] = 32'h4; en[0] = 1'b1;
        ctl[1] = 32'h0C; row[1] = 32'h3; en[1] = 1'b1;
        ctl[2] = 32'h0A; row[2] = 32'h4; en[2] = 1'b0;
        for (int t = 0; t < 3; t++) begin
            wb_write(32'h04, row[t]);
            enable_im = en[t];
            wb_write(32'h00, ctl[t]);
            for (int c = 0; c < 4; c++) begin
                step();
                total++;
                if ({wl_en, bl_en, sl_en, csa_en, adc_start} !== '0) begin
                    bad++;
                    $display("FAIL illegal%0d_idle: got wl=%h bl=%h sl=%b want 0", t, wl_en, bl_en, sl_en);
                end
            end
            wb_read(32'h10, rd);
            total++;
            if (rd !== 32'h4) begin bad++; $display("FAIL illegal%0d_status: got %h want 4", t, rd); end
            wb_write(32'h10, 32'hE);
            enable_im = 1'b1;
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int n;
        wb_write(32'h04, 32'h0000_0001);
        wb_write(32'h0C, 32'h0000_0101);
        wb_write(32'h00, 32'h0000_0004 | 32'h8);
        n = 0;
        while (adc_start !== 1'b1 && n < 40) begin step(); n++; end
        step();
        total++;
        if (csa_en !== 1'b1) begin bad++; $display("FAIL abort_pre: got csa=%b want 1", csa_en); end
        enable_im = 1'b0;
        step();
        total++;
        if ({wl_en, bl_en, sl_en, csa_en, adc_start, vsel} !== '0) begin
            bad++; $display("FAIL abort_outputs: got wl=%h bl=%h csa=%b want 0", wl_en, bl_en, csa_en);
        end
        wb_read(32'h10, rd);
        total++;
        if (rd !== 32'hC) begin bad++; $display("FAIL abort_status: got %h want c", rd); end
        wb_write(32'h10, 32'hE);
        wb_read(32'h10, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL abort_w1c: got %h want 0", rd); end
        enable_im = 1'b1;
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] rd;
        int n;
        wb_write(32'h04, 32'h0000_0004);
        wb_write(32'h08, 32'h0000_00F0);
        wb_write(32'h0C, 32'h0000_0114);
        wb_write(32'h00, 32'h0000_000A);
        n = 0;
        while (wl_en === 16'h0 && n < 40) begin step(); n++; end
        total++;
        if (wl_en !== 16'h0004) begin bad++; $display("FAIL rst_pulse_pre: got %h want 0004", wl_en); end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({wl_en, bl_en, sl_en, vsel, csa_en, adc_start, irq} !== '0) begin
            bad++; $display("FAIL rst_async: got wl=%h bl=%h sl=%b vsel=%0d want 0", wl_en, bl_en, sl_en, vsel);
        end
        #4 rst = 1'b1;
        step();
        wb_read(32'h10, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL rst_status: got %h want 0", rd); end
        wb_read(32'h04, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL rst_rowmask: got %h want 0", rd); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_set();
        test_read();
        test_timeout();
        test_illegal();
        test_abort();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rram_imc_ctrl.md
# rram_imc_ctrl

Parametrised Wishbone-slave sequencer for the RRAM in-memory-compute macro: it replaces direct, free-running drive of the array control pins with a register-programmed operation engine. It generates timed word-line, bit-line and source-line enable pulses for FORM/SET/RESET/READ/COMPUTE operations, strobes the current-sense amplifiers and ADCs, and captures the ADC outputs into readable result registers. It sits between the user-area Wishbone port and the analog array macro. Analog reference voltages stay on `analog_io`; this block drives only the digital selects and enables.

## Interface
- `ROWS`, 16: word-lines (1..32).
- `COLS`, 16: bit-line/ADC columns (1..32).
- `ADC_BITS`, 3: bits per column ADC result (1..8).
- `CNT_W`, 8: width of the pulse, settle and timeout counters.

- `clk` in 1: single clock, the Wishbone clock.
- `rst` in 1: reset, **asynchronous, active-low**.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i` in 1: Wishbone classic strobes.
- `wbs_sel_i` in 4: byte lanes. Only lane-0 writes matter for CTRL/PULSE; mask registers honour all lanes.
- `wbs_adr_i` in 32: only bits [6:2] are decoded.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: one-cycle acknowledge.
- `wbs_dat_o` out 32: read data. Reads 0 when not acking.
- `enable_im` in 1: global enable from the logic analyser.
- `wl_en` out ROWS: word-line enables.
- `bl_en` out COLS: bit-line enables.
- `sl_en` out 1: source-line enable.
- `vsel` out 2: voltage-mux select. 0 = read/compute, 1 = set, 2 = reset, 3 = form.
- `csa_en` out 1: sense-amp enable.
- `adc_start` out 1: single-cycle ADC start pulse.
- `adc_done` in 1: ADC conversion complete.
- `adc_data` in COLS*ADC_BITS: packed ADC results, column 0 in the LSBs.
- `irq` out 1: level interrupt, equal to STATUS.done AND CTRL.ie.

## Operation
Register map (word offsets):
- 0x00 CTRL:
  - [2:0] op: 1 FORM, 2 SET, 3 RESET, 4 READ, 5 COMPUTE.
  - [3] start: write-1, self-clearing, always reads 0.
  - [4] ie.
- 0x04 ROW_MASK [ROWS-1:0].
- 0x08 COL_MASK [COLS-1:0].
- 0x0C PULSE:
  - [CNT_W-1:0] pulse cycles.
  - [CNT_W+7:8] settle cycles.
- 0x10 STATUS: [0] busy (RO), [1] done (sticky, W1C), [2] err (sticky, W1C), [3] abort (sticky, W1C).
- 0x14 onward RESULT_k, read-only: packed captured results, 32 bits per word, ceil(COLS*ADC_BITS/32) words. Unused upper bits read 0.
- Unmapped offsets read 0; writes to them are ignored.

Wishbone:
- `wbs_ack_o` is registered: it asserts the cycle after `cyc&stb` is seen with ack low, for exactly 1 cycle.
- Back-to-back requests are acked every other cycle.

Start conditions:
- Accepted only when idle, `enable_im`=1, and op is in 1..5.
- Otherwise STATUS.err is set and nothing runs.
- Writes to CTRL/MASK/PULSE while busy are acked and ignored. err is not set.

FSM states: IDLE, SETUP, PULSE, DISCH, SENSE, WAIT_ADC, CAPTURE, DONE.
- **IDLE → SETUP:** on an accepted start. Latch op, masks and counts; drive `vsel`; busy=1.
- **SETUP:** hold for settle cycles, then go to PULSE.
- **PULSE:** drive `wl_en`=ROW_MASK, `bl_en`=COL_MASK, `sl_en`=1 for pulse cycles.
  - Program ops (FORM/SET/RESET) → DISCH.
  - READ/COMPUTE keep the enables asserted and go to SENSE.
- **DISCH:** all enables 0 for settle cycles, then DONE.
- **SENSE:** `csa_en`=1 and `adc_start`=1 for one cycle, then WAIT_ADC.
- **WAIT_ADC:** hold `csa_en` and enables.
  - On `adc_done` → CAPTURE.
  - After 2^CNT_W-1 cycles without `adc_done` → err=1, go to DISCH, RESULT unchanged.
- **CAPTURE:** latch `adc_data` into RESULT, then go to DISCH.
- **DONE:** done=1, busy=0, then IDLE.

Rules:
- READ requires exactly one ROW_MASK bit set. COMPUTE allows any nonzero mask.
- A zero mask on any op → err, no run.
- A count of 0 is treated as 1.
- `enable_im` falling while busy: next cycle all outputs deassert, abort=1 and err=1, FSM → IDLE. done is not set.

## Timing
- Reset values: all outputs 0 (`vsel`=0), all registers 0, FSM in IDLE.
- Start is accepted on the cycle the write is acked. SETUP begins the following cycle.
- Enables assert on the first PULSE cycle and deassert on the first DISCH cycle.
- Program-op latency from ack to done=1 is settle + pulse + settle + 1 cycles.
- `adc_data` is sampled in the same cycle `adc_done` is seen high.
- When a W1C and a hardware set of STATUS occur in the same cycle, the set wins.

## Test plan
- **Reset mid-PULSE:** assert `rst` low during PULSE → all outputs 0 immediately (asynchronously); STATUS reads 0 after release.
- **SET:** ROW_MASK=0x0004, COL_MASK=0x00F0, settle=2, pulse=5, op=2 start → `vsel`=1; `wl_en`=0x0004 and `bl_en`=0x00F0 for exactly 5 cycles; done=1 at ack+10.
- **READ:** ROW_MASK=0x0001, op=4; `adc_done` driven 3 cycles after `adc_start` with `adc_data`=0x2A5 → RESULT_0 reads 0x2A5, done=1, irq=ie.
- **ADC timeout:** COMPUTE with `adc_done` held 0 → err=1 after 255 WAIT_ADC cycles; enables drop; RESULT unchanged.
- **Illegal starts:** op=6, then READ with ROW_MASK=0x0003, then any start with `enable_im`=0 → each sets err, busy stays 0, no enable ever toggles.
- **Abort:** drop `enable_im` during WAIT_ADC → abort=1, outputs 0 next cycle; write 0xE to STATUS → reads 0.
